// File: rtl/sdram_refr_ctrl_if.sv
// Refresh-engine bus: arbiter handshake, command/address toward the command mux, and status.
// master = refresh engine, slave = arbiter / command mux side.
interface sdram_refr_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int PEND_W = 3
) ();
    logic              refr_en;
    logic              refr_req;
    logic              refr_urgent;
    logic              refr_end;
    logic [3:0]        refr_cmd;
    logic [ADDR_W-1:0] refr_addr;
    logic [PEND_W-1:0] refr_pend;
    logic              refr_ovf;

    modport master (
        input  refr_en,
        output refr_req, refr_urgent, refr_end, refr_cmd, refr_addr, refr_pend, refr_ovf
    );

    modport slave (
        output refr_en,
        input  refr_req, refr_urgent, refr_end, refr_cmd, refr_addr, refr_pend, refr_ovf
    );
endinterface

// File: rtl/sdram_refr_ctrl.sv
// SDRAM auto-refresh engine: interval credit generator with postponement queue,
// and a PRE-ALL + AREF_NUM x AREF sequencer run on arbiter grant.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | NOP; waits for refr_en while credits are pending
// PRE      | PRECHARGE-ALL issued this cycle
// WAIT_RP  | NOP for T_RP-1 cycles
// AREF     | AUTO-REFRESH issued this cycle
// WAIT_RFC | NOP for T_RFC-1 cycles, then next AREF or DONE
// DONE     | NOP, refr_end pulse, one credit consumed
module sdram_refr_ctrl #(
    parameter int REFR_INTERVAL = 750,
    parameter int T_RP          = 2,
    parameter int T_RFC         = 7,
    parameter int AREF_NUM      = 2,
    parameter int MAX_PEND      = 4,
    parameter int URG_THR       = 3,
    parameter int ADDR_W        = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    sdram_refr_ctrl_if.master bus
);
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int CNT_W  = (REFR_INTERVAL > 1) ? $clog2(REFR_INTERVAL) : 1;
    localparam int WT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WT_W   = (WT_MAX > 1) ? $clog2(WT_MAX) : 1;
    localparam int AC_W   = (AREF_NUM > 1) ? $clog2(AREF_NUM) : 1;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFR_INTERVAL - 1);
    localparam logic [WT_W-1:0]   RP_LOAD  = (T_RP > 1)  ? WT_W'(T_RP - 2)  : '0;
    localparam logic [WT_W-1:0]   RFC_LOAD = (T_RFC > 1) ? WT_W'(T_RFC - 2) : '0;
    localparam logic [AC_W-1:0]   AC_LAST  = AC_W'(AREF_NUM - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URG_THR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_AREF,
        S_WAIT_RFC,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WT_W-1:0]   wait_cnt, wait_nxt;
    logic [AC_W-1:0]   aref_cnt, aref_nxt;
    logic [3:0]        cmd_q, cmd_nxt;
    logic              end_q, end_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pend;
    logic              ovf;
    logic              tick;
    logic              done;

    assign tick = (cnt == CNT_LAST);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        aref_nxt  = aref_cnt;
        case (state)
            S_IDLE: begin
                aref_nxt = '0;
                if (bus.refr_en && (pend != '0))
                    state_nxt = S_PRE;
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    state_nxt = S_AREF;
                end else begin
                    state_nxt = S_WAIT_RP;
                    wait_nxt  = RP_LOAD;
                end
            end
            S_WAIT_RP: begin
                if (wait_cnt == '0)
                    state_nxt = S_AREF;
                else
                    wait_nxt = wait_cnt - WT_W'(1);
            end
            S_AREF: begin
                if (T_RFC > 1) begin
                    state_nxt = S_WAIT_RFC;
                    wait_nxt  = RFC_LOAD;
                end else if (aref_cnt < AC_LAST) begin
                    state_nxt = S_AREF;
                    aref_nxt  = aref_cnt + AC_W'(1);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_RFC: begin
                if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - WT_W'(1);
                end else if (aref_cnt < AC_LAST) begin
                    state_nxt = S_AREF;
                    aref_nxt  = aref_cnt + AC_W'(1);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command and end pulse are registered from the next state so they line up with state occupancy.
    always_comb begin
        cmd_nxt = CMD_NOP;
        if (state_nxt == S_PRE)
            cmd_nxt = CMD_PRE;
        else if (state_nxt == S_AREF)
            cmd_nxt = CMD_AREF;
        end_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            aref_cnt <= '0;
            cmd_q    <= CMD_NOP;
            end_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            aref_cnt <= aref_nxt;
            cmd_q    <= cmd_nxt;
            end_q    <= end_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // A credit arriving in the same cycle as a completion cancels out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else if (tick && !done) begin
            if (pend == PEND_MAX)
                ovf <= 1'b1;
            else
                pend <= pend + PEND_W'(1);
        end else if (done && !tick) begin
            pend <= pend - PEND_W'(1);
        end
    end

    assign bus.refr_cmd    = cmd_q;
    assign bus.refr_end    = end_q;
    assign bus.refr_req    = (state == S_IDLE) && (pend != '0);
    assign bus.refr_urgent = (pend >= PEND_URG);
    assign bus.refr_pend   = pend;
    assign bus.refr_ovf    = ovf;
    assign bus.refr_addr   = ADDR_W'(11'h400);
endmodule

// File: tb/tb_sdram_refr_ctrl.sv
// Directed bench for sdram_refr_ctrl: default instance plus a minimum-timing instance
// (T_RP=T_RFC=AREF_NUM=1, short interval).
module tb_sdram_refr_ctrl;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   edge_a;
    int   edge_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sdram_refr_ctrl_if #(.ADDR_W(12), .PEND_W(3)) bus_a ();
    sdram_refr_ctrl_if #(.ADDR_W(12), .PEND_W(3)) bus_b ();

    sdram_refr_ctrl #(
        .REFR_INTERVAL(750), .T_RP(2), .T_RFC(7), .AREF_NUM(2),
        .MAX_PEND(4), .URG_THR(3), .ADDR_W(12)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_a_n), .bus(bus_a.master)
    );

    sdram_refr_ctrl #(
        .REFR_INTERVAL(20), .T_RP(1), .T_RFC(1), .AREF_NUM(1),
        .MAX_PEND(4), .URG_THR(3), .ADDR_W(12)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_b_n), .bus(bus_b.master)
    );

    always @(posedge clk or negedge rst_a_n)
        if (!rst_a_n) edge_a <= 0;
        else          edge_a <= edge_a + 1;

    always @(posedge clk or negedge rst_b_n)
        if (!rst_b_n) edge_b <= 0;
        else          edge_b <= edge_b + 1;

    logic [3:0] cmd_log  [1:24];
    logic       end_log  [1:24];
    logic       req_log  [1:24];
    logic [2:0] pend_log [1:24];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge_a(input int n);
        while (edge_a < n) @(negedge clk);
    endtask

    task automatic wait_edge_b(input int n);
        while (edge_b < n) @(negedge clk);
    endtask

    // Grant dut_a for ncyc cycles, logging outputs one half-cycle after each edge.
    task automatic run_grant(input int drop_c, input int ncyc);
        bus_a.refr_en = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            cmd_log[c]  = bus_a.refr_cmd;
            end_log[c]  = bus_a.refr_end;
            req_log[c]  = bus_a.refr_req;
            pend_log[c] = bus_a.refr_pend;
            if (c == drop_c || bus_a.refr_end) bus_a.refr_en = 1'b0;
        end
        bus_a.refr_en = 1'b0;
    endtask

    // Default timing: PRE @1, AREF @3 and @10, refr_end only @17.
    task automatic check_seq(input string tag);
        logic [3:0] exp;
        int         n_end;
        n_end = 0;
        for (int c = 1; c <= 20; c++) begin
            exp = NOP;
            if (c == 1) exp = PRE;
            if (c == 3 || c == 10) exp = AREF;
            check($sformatf("%s cmd@%0d", tag, c), {28'd0, cmd_log[c]}, {28'd0, exp});
            if (end_log[c] === 1'b1) n_end++;
        end
        check({tag, " end@17"}, {31'd0, end_log[17]}, 32'd1);
        check({tag, " end count"}, n_end, 32'd1);
    endtask

    initial begin
        int bad;
        int exp_p  [5] = '{1, 2, 3, 4, 4};
        int exp_u  [5] = '{0, 0, 1, 1, 1};
        int exp_o  [5] = '{0, 0, 0, 0, 1};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.refr_en = 1'b0;
        bus_b.refr_en = 1'b0;
        repeat (3) @(negedge clk);

        check("rst cmd",    {28'd0, bus_a.refr_cmd}, {28'd0, NOP});
        check("rst pend",   {29'd0, bus_a.refr_pend}, 32'd0);
        check("rst req",    {31'd0, bus_a.refr_req}, 32'd0);
        check("rst urgent", {31'd0, bus_a.refr_urgent}, 32'd0);
        check("rst end",    {31'd0, bus_a.refr_end}, 32'd0);
        check("rst ovf",    {31'd0, bus_a.refr_ovf}, 32'd0);
        check("rst addr",   {20'd0, bus_a.refr_addr}, 32'h400);

        // first credit after the 750th edge
        rst_a_n = 1'b1;
        bad = 0;
        while (edge_a < 749) begin
            @(negedge clk);
            if (bus_a.refr_cmd !== NOP || bus_a.refr_req !== 1'b0) bad++;
        end
        check("t1 quiet before tick", bad, 32'd0);
        check("t1 pend @749", {29'd0, bus_a.refr_pend}, 32'd0);
        @(negedge clk);
        check("t1 req @750",  {31'd0, bus_a.refr_req}, 32'd1);
        check("t1 pend @750", {29'd0, bus_a.refr_pend}, 32'd1);
        check("t1 cmd @750",  {28'd0, bus_a.refr_cmd}, {28'd0, NOP});

        // single grant
        run_grant(0, 20);
        check_seq("t2");
        check("t2 pend in DONE",  {29'd0, pend_log[17]}, 32'd1);
        check("t2 pend after",    {29'd0, pend_log[18]}, 32'd0);
        check("t2 req after",     {31'd0, req_log[18]}, 32'd0);
        check("t2 req stays low", {31'd0, req_log[20]}, 32'd0);

        // five ticks without a grant
        for (int k = 0; k < 5; k++) begin
            wait_edge_a(750 * (k + 2));
            check($sformatf("t3 pend tick%0d", k + 1), {29'd0, bus_a.refr_pend}, exp_p[k]);
            check($sformatf("t3 urgent tick%0d", k + 1), {31'd0, bus_a.refr_urgent}, exp_u[k]);
            check($sformatf("t3 ovf tick%0d", k + 1), {31'd0, bus_a.refr_ovf}, exp_o[k]);
        end

        // drain to 2, then land DONE on the tick at edge 5250
        run_grant(0, 20);
        run_grant(0, 20);
        check("t4 pend drained", {29'd0, pend_log[20]}, 32'd2);
        wait_edge_a(5232);
        run_grant(0, 20);
        check("t4 end@17",          {31'd0, end_log[17]}, 32'd1);
        check("t4 req in DONE",     {31'd0, req_log[17]}, 32'd0);
        check("t4 pend after tick", {29'd0, pend_log[18]}, 32'd2);
        check("t4 req re-rise",     {31'd0, req_log[18]}, 32'd1);
        check("t4 ovf sticky",      {31'd0, bus_a.refr_ovf}, 32'd1);

        // grant withdrawn in WAIT_RP
        run_grant(2, 20);
        check_seq("t5a");
        check("t5a pend after", {29'd0, pend_log[20]}, 32'd1);
        check("t5a req after",  {31'd0, req_log[20]}, 32'd1);

        // reset in WAIT_RFC
        bus_a.refr_en = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_a_n = 1'b0;
        bus_a.refr_en = 1'b0;
        #1;
        check("t6 cmd in rst",  {28'd0, bus_a.refr_cmd}, {28'd0, NOP});
        check("t6 pend in rst", {29'd0, bus_a.refr_pend}, 32'd0);
        check("t6 req in rst",  {31'd0, bus_a.refr_req}, 32'd0);
        check("t6 ovf in rst",  {31'd0, bus_a.refr_ovf}, 32'd0);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.refr_cmd !== NOP || bus_a.refr_end !== 1'b0) bad++;
        end
        check("t6 no cmd after rst", bad, 32'd0);
        wait_edge_a(750);
        check("t6 pend restart", {29'd0, bus_a.refr_pend}, 32'd1);
        check("t6 req restart",  {31'd0, bus_a.refr_req}, 32'd1);
        run_grant(0, 20);
        check_seq("t6 post");

        // minimum-timing instance; grant with no credit is ignored
        rst_b_n = 1'b1;
        bus_b.refr_en = 1'b1;
        bad = 0;
        while (edge_b < 19) begin
            @(negedge clk);
            if (bus_b.refr_cmd !== NOP || bus_b.refr_req !== 1'b0) bad++;
        end
        check("t5b grant w/o credit", bad, 32'd0);
        bus_b.refr_en = 1'b0;
        wait_edge_b(20);
        check("t5b pend", {29'd0, bus_b.refr_pend}, 32'd1);
        check("t5b req",  {31'd0, bus_b.refr_req}, 32'd1);
        bus_b.refr_en = 1'b1;
        @(negedge clk);
        check("t5b cmd c1", {28'd0, bus_b.refr_cmd}, {28'd0, PRE});
        @(negedge clk);
        check("t5b cmd c2", {28'd0, bus_b.refr_cmd}, {28'd0, AREF});
        check("t5b end c2", {31'd0, bus_b.refr_end}, 32'd0);
        @(negedge clk);
        check("t5b cmd c3", {28'd0, bus_b.refr_cmd}, {28'd0, NOP});
        check("t5b end c3", {31'd0, bus_b.refr_end}, 32'd1);
        bus_b.refr_en = 1'b0;
        @(negedge clk);
        check("t5b end c4",  {31'd0, bus_b.refr_end}, 32'd0);
        check("t5b pend c4", {29'd0, bus_b.refr_pend}, 32'd0);
        check("t5b req c4",  {31'd0, bus_b.refr_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
